mx_e4m3_block_encoder: RTL and testbench
========================================

Name: mx_e4m3_block_encoder

Overview:
- Converts a stream of BF16 values into one packed MXFP8 E4M3 vector per block of 32.
- Layout of the output vector: 8-bit E8M0 shared scale plus 32 E4M3 elements.
- It is the encode side of the MX format definitions: the producer of vectors that the MX ALU datapaths parse.
- Sits between a BF16 activation/weight stream and MX operand storage.

Parameters:
- BLOCK_SIZE, 32, elements per scaling block (equals SCALING_BLOCK_SIZE); the design and tests target 32 only.
- ELEM_EMAX, 8, unbiased max exponent of E4M3, used to derive the scale.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  BF16 element valid.
- in_ready  out  1  encoder can accept an element.
- in_data  in  16  BF16 {sign, exp[7:0] bias 127, man[6:0]}.
- out_valid  out  1  packed vector valid.
- out_ready  in  1  consumer accepts vector.
- out_vector  out  264  {scale[7:0], elem[31]..elem[0]}; elem[0] occupies bits [7:0].

Behaviour:
- Interface: one clock, reset synchronous and active-high (clk, rst).
- Reset values: state COLLECT, count 0, running max exponent 0, nan flag 0, in_ready 1, out_valid 0, out_vector 0.
- Reset mid-operation discards the partial block and any pending vector.

FSM states:
- COLLECT:
  - in_ready=1.
  - On in_valid&&in_ready: store in_data in buf[count] and increment count.
  - Update emax = max(emax, exp) over inputs with exp != 0.
  - Set nan flag if exp == 255.
  - Accepting element 31 moves to CONVERT; count wraps to 0.
- CONVERT:
  - in_ready=0.
  - Scale X is latched on entry, computed from emax/nan including the last element.
  - Converts one element per cycle, index 0..31, writing elem[i].
  - After index 31 moves to OUTPUT.
- OUTPUT:
  - out_valid=1; out_vector is stable while out_valid=1 and out_ready=0.
  - On out_ready, moves to COLLECT; in_ready is 1 the next cycle.
- Timing: out_valid rises 32 cycles after the clock edge that accepts the last input element. in_valid is ignored while in_ready=0.

Scale (E8M0):
- If nan=1: X = 0xFF.
- Otherwise X = max(emax - ELEM_EMAX, 0), using a 9-bit signed intermediate.

Element conversion:
- Input e, m, sign s.
- Input exp == 0 (zero or BF16 subnormal) → element {s, 7'b0} (flush to zero).
- nan=1 → all elements 0x00.
- Compute d = e - X + 7 (signed, ≥10 bits). Invariant: d ≤ 15.
- Normal (d ≥ 1): element {s, d[3:0], m[6:4]}, rounding toward zero (truncate).
  - If d == 15 and m[6:4] == 3'b111, output {s, 4'hF, 3'b110} (saturate to ±448; never emit NaN).
- Subnormal (d ≤ 0): sig = {1, m[6:0]}; mantissa field = sig >> (5 - d), truncated to 3 bits; element {s, 4'b0, field}.
  - If 5 - d ≥ 8, the field is 0 (the sign is kept).

Test Plan:
- Basic block: 32× 0x3F80 (1.0) → scale 0x77, all elements 0x78.
  - Also check: out_valid exactly 32 cycles after the last accept; in_ready=0 throughout CONVERT/OUTPUT.
- Mixed magnitudes: elem0=0x4380 (256.0), elem1=0xBF80 (-1.0), elem2=0x3B80 (2^-8), elem3=0x3A00 (2^-11), rest 0x0000.
  - Expected: scale 0x7F; elem0 0x78, elem1 0xB8, elem2 0x02, elem3 0x00, rest 0x00.
- Saturation: 32× 0x3FFF → scale 0x77, all elements 0x7E (not 0x7F).
- NaN/Inf: element 5 = 0x7FC0, others 1.0 → scale 0xFF, all elements 0x00.
  - Next block of 32× 1.0 → scale 0x77 (nan flag cleared).
- Handshakes:
  - Random in_valid gaps give identical results.
  - Hold out_ready=0 for 10 cycles: out_vector stable, in_ready stays 0; handshake, then the next block is accepted on the following cycle.
  - All-zero block → scale 0x00, elements 0x00.
- Reset mid-block: after 17 inputs assert rst for 1 cycle → in_ready=1, out_valid=0.
  - A fresh 32× 1.0 block then yields scale 0x77 / 0x78 (no stale data).

Source files
------------

// File: rtl/mx_e4m3_block_encoder.sv
// mx_e4m3_block_encoder
// ---------------------------------------------------------------------------
// Collects a stream of BF16 values into blocks of BLOCK_SIZE elements and
// emits one packed MXFP8 E4M3 vector per block: an E8M0 shared scale followed
// by BLOCK_SIZE E4M3 elements. Elements are converted one per cycle after the
// last input of a block has been accepted.
//
// Ports:
//   i_clk        single clock, rising edge
//   i_rst        synchronous reset, active-high
//   i_in_valid   BF16 element valid
//   o_in_ready   encoder can accept an element (only while collecting)
//   i_in_data    BF16 {sign, exp[7:0] bias 127, man[6:0]}
//   o_out_valid  packed vector valid
//   i_out_ready  consumer accepts the vector
//   o_out_vector {scale[7:0], elem[N-1]..elem[0]}; elem[0] in bits [7:0]
// ---------------------------------------------------------------------------
module mx_e4m3_block_encoder #(
    parameter int BLOCK_SIZE = 32,
    parameter int ELEM_EMAX  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [15:0]               i_in_data,
    output logic                      o_out_valid,
    input  logic                      i_out_ready,
    output logic [8*BLOCK_SIZE+7:0]   o_out_vector
);

    localparam int IDX_W = $clog2(BLOCK_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

    typedef enum logic [1:0] {
        COLLECT,
        CONVERT,
        OUTPUT
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;

    logic [15:0]        r_buf [BLOCK_SIZE];
    logic [7:0]         r_elemArr [BLOCK_SIZE];
    logic [IDX_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_emax;
    logic               r_nan;
    logic [7:0]         r_scale;
    logic               r_blkNan;

    logic               w_accept;
    logic [7:0]         w_inExp;
    logic [7:0]         w_emaxNext;
    logic               w_nanNext;
    logic signed [8:0]  w_scaleDiff;
    logic [7:0]         w_scaleNext;

    logic [15:0]        w_cur;
    logic signed [9:0]  w_d;
    logic signed [9:0]  w_shift;
    logic [7:0]         w_sig;
    logic [2:0]         w_subField;
    logic [7:0]         w_elem;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake outputs. Input is only taken while collecting,
    // and the vector is only offered once every element has been converted.
    always_comb begin
        w_stateNext = r_state;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            COLLECT: begin
                o_in_ready = 1'b1;
                if (i_in_valid && (r_count == LAST_IDX)) begin
                    w_stateNext = CONVERT;
                end
            end
            CONVERT: begin
                if (r_idx == LAST_IDX) begin
                    w_stateNext = OUTPUT;
                end
            end
            OUTPUT: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_stateNext = COLLECT;
                end
            end
            default: w_stateNext = COLLECT;
        endcase
    end

    assign w_accept = i_in_valid && o_in_ready;
    assign w_inExp  = i_in_data[14:7];

    // Running statistics including the element being accepted this cycle, so
    // the scale can be latched on the same edge that takes the last element.
    // Zero-exponent inputs (zero and BF16 subnormals) flush to zero and so
    // must not influence the shared exponent.
    assign w_emaxNext  = ((w_inExp != 8'd0) && (w_inExp > r_emax)) ? w_inExp : r_emax;
    assign w_nanNext   = r_nan | (w_inExp == 8'hFF);
    assign w_scaleDiff = $signed({1'b0, w_emaxNext}) - 9'(ELEM_EMAX);
    assign w_scaleNext = w_nanNext ? 8'hFF : (w_scaleDiff[8] ? 8'd0 : w_scaleDiff[7:0]);

    // Element buffer; contents are always fully rewritten before use.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_buf[r_count] <= i_in_data;
        end
    end

    // Block bookkeeping and the converted-element register. The per-block
    // statistics are cleared as the scale is latched so the next block starts
    // fresh while this one is still being converted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_idx    <= '0;
            r_emax   <= 8'd0;
            r_nan    <= 1'b0;
            r_scale  <= 8'd0;
            r_blkNan <= 1'b0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                r_elemArr[i] <= 8'd0;
            end
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_accept) begin
                        if (r_count == LAST_IDX) begin
                            r_count  <= '0;
                            r_idx    <= '0;
                            r_scale  <= w_scaleNext;
                            r_blkNan <= w_nanNext;
                            r_emax   <= 8'd0;
                            r_nan    <= 1'b0;
                        end else begin
                            r_count <= r_count + 1'b1;
                            r_emax  <= w_emaxNext;
                            r_nan   <= w_nanNext;
                        end
                    end
                end
                CONVERT: begin
                    r_elemArr[r_idx] <= w_elem;
                    r_idx            <= r_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Conversion of the element at r_idx. d is the E4M3 biased exponent after
    // removing the shared scale; since the scale is derived from the largest
    // exponent, d never exceeds 15. Truncation toward zero throughout, and the
    // top code (which would be NaN in E4M3) is clamped to 448.
    assign w_cur      = r_buf[r_idx];
    assign w_d        = $signed({2'b00, w_cur[14:7]}) - $signed({2'b00, r_scale}) + 10'sd7;
    assign w_shift    = 10'sd5 - w_d;
    assign w_sig      = {1'b1, w_cur[6:0]};
    assign w_subField = 3'(w_sig >> w_shift[2:0]);

    always_comb begin
        w_elem = 8'h00;
        if (r_blkNan) begin
            w_elem = 8'h00;
        end else if (w_cur[14:7] == 8'd0) begin
            w_elem = {w_cur[15], 7'b0};
        end else if (w_d > 10'sd0) begin
            if ((w_d == 10'sd15) && (w_cur[6:4] == 3'b111)) begin
                w_elem = {w_cur[15], 4'hF, 3'b110};
            end else begin
                w_elem = {w_cur[15], w_d[3:0], w_cur[6:4]};
            end
        end else if (w_shift >= 10'sd8) begin
            w_elem = {w_cur[15], 7'b0};
        end else begin
            w_elem = {w_cur[15], 4'b0, w_subField};
        end
    end

    // Packed output: scale on top, element 0 in the least significant byte.
    always_comb begin
        o_out_vector = '0;
        o_out_vector[8*BLOCK_SIZE +: 8] = r_scale;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            o_out_vector[8*i +: 8] = r_elemArr[i];
        end
    end

endmodule

// File: tb/tb_mx_e4m3_block_encoder.sv
// tb_mx_e4m3_block_encoder
// ---------------------------------------------------------------------------
// Scoreboarded bench for mx_e4m3_block_encoder. Each issued block pushes its
// expected vector (from a value-level reference model) into a queue; a
// monitor pops and compares whenever a vector is handed over.
// ---------------------------------------------------------------------------
module tb_mx_e4m3_block_encoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [15:0]  inData;
    logic         outValid;
    logic         outReady;
    logic [263:0] outVector;

    int nChecks = 0;
    int nPass   = 0;

    logic [15:0]  blkData [32];
    logic [263:0] expQ [$];

    mx_e4m3_block_encoder #(
        .BLOCK_SIZE (32),
        .ELEM_EMAX  (8)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (inValid),
        .o_in_ready   (inReady),
        .i_in_data    (inData),
        .o_out_valid  (outValid),
        .i_out_ready  (outReady),
        .o_out_vector (outVector)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [263:0] act, input logic [263:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Value of an E4M3 magnitude code in units of 2^-9 (the smallest subnormal).
    function automatic longint e4m3Units(input int code);
        int e;
        int m;
        e = code >> 3;
        m = code & 7;
        if (e == 0) return longint'(m);
        return longint'(8 + m) << (e - 1);
    endfunction

    // Reference model: shared exponent from the largest normal input, then
    // each value divided by 2^scale and truncated to the largest finite E4M3
    // magnitude not exceeding it (0x7E = 448 is the largest finite code).
    function automatic logic [263:0] refEncode();
        logic [263:0] v;
        bit anyNan;
        int emax;
        int x;
        int s;
        int e;
        int sig;
        int p;
        int best;
        longint q;
        anyNan = 1'b0;
        emax = 0;
        v = '0;
        for (int i = 0; i < 32; i++) begin
            e = int'(blkData[i][14:7]);
            if (e == 255) anyNan = 1'b1;
            if (e != 0 && e > emax) emax = e;
        end
        x = anyNan ? 255 : ((emax - 8 < 0) ? 0 : emax - 8);
        v[263:256] = 8'(x);
        for (int i = 0; i < 32; i++) begin
            s   = int'(blkData[i][15]);
            e   = int'(blkData[i][14:7]);
            sig = 128 + int'(blkData[i][6:0]);
            if (anyNan) begin
                v[8*i +: 8] = 8'h00;
            end else if (e == 0) begin
                v[8*i +: 8] = {1'(s), 7'b0};
            end else begin
                // |value| / 2^(x-127) expressed in units of 2^-9, floored
                p = e - x + 2;
                if (p >= 0) q = longint'(sig) << p;
                else if (-p >= 40) q = 0;
                else q = longint'(sig) >> (-p);
                best = 0;
                for (int c = 0; c < 127; c++) begin
                    if (e4m3Units(c) <= q) best = c;
                end
                v[8*i +: 8] = {1'(s), 7'(best)};
            end
        end
        return v;
    endfunction

    // Monitor: a vector is handed over when valid and ready are both high.
    always @(negedge clk) begin
        logic [263:0] exp;
        if (!rst && outValid && outReady) begin
            if (expQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpected vector: actual=%0h required=none", outVector);
            end else begin
                exp = expQ.pop_front();
                checkOutput("scale", {256'd0, outVector[263:256]}, {256'd0, exp[263:256]});
                checkOutput("elements", {8'd0, outVector[255:0]}, {8'd0, exp[255:0]});
            end
        end
    end

    // Drives one element, optionally preceded by random idle cycles, and
    // returns once it has been accepted (phase: 1 time unit after posedge).
    task automatic sendElement(input logic [15:0] d, input int gapPct);
        int w;
        while ($urandom_range(99) < gapPct) begin
            inValid = 1'b0;
            inData  = 16'($urandom);
            @(posedge clk);
            #1;
        end
        inValid = 1'b1;
        inData  = d;
        w = 0;
        while (!inReady && w < 200) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (w >= 200) begin
            nChecks++;
            $display("[TB] FAIL accept timeout: actual=in_ready stuck low required=accept");
        end
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    // Sends blkData as one block and checks latency, in_ready suppression and
    // (when holdCycles > 0) output stability under back-pressure.
    task automatic applyStimulus(input int gapPct, input int holdCycles);
        int lat;
        bit readyLeak;
        bit stable;
        logic [263:0] snap;
        expQ.push_back(refEncode());
        outReady = (holdCycles == 0);
        for (int i = 0; i < 32; i++) begin
            sendElement(blkData[i], gapPct);
        end
        lat = 0;
        readyLeak = 1'b0;
        while (!outValid && lat < 100) begin
            if (inReady) readyLeak = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (inReady) readyLeak = 1'b1;
        checkOutput("latency", 264'(lat), 264'd32);
        checkOutput("in_ready low while busy", {263'd0, readyLeak}, 264'd0);
        if (holdCycles > 0) begin
            snap = outVector;
            stable = 1'b1;
            for (int h = 0; h < holdCycles; h++) begin
                @(posedge clk);
                #1;
                if (outVector !== snap || inReady || !outValid) stable = 1'b0;
            end
            checkOutput("stall stability", {263'd0, stable}, 264'd1);
            outReady = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("in_ready after handshake", {263'd0, inReady}, 264'd1);
        checkOutput("out_valid after handshake", {263'd0, outValid}, 264'd0);
    endtask

    task automatic fillBlock(input logic [15:0] d);
        for (int i = 0; i < 32; i++) blkData[i] = d;
    endtask

    task automatic fillRandom(input bit allowNan);
        int base;
        int e;
        base = $urandom_range(230, 20);
        for (int i = 0; i < 32; i++) begin
            e = base - int'($urandom_range(20, 0));
            if ($urandom_range(7) == 0) e = 0;
            blkData[i] = {1'($urandom), 8'(e), 7'($urandom)};
        end
        if (allowNan) blkData[$urandom_range(31)][14:7] = 8'hFF;
    endtask

    initial begin
        int w;
        rst      = 1'b1;
        inValid  = 1'b0;
        inData   = 16'h0000;
        outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", {263'd0, inReady}, 264'd1);
        checkOutput("reset out_valid", {263'd0, outValid}, 264'd0);
        checkOutput("reset out_vector", outVector, 264'd0);
        rst = 1'b0;

        $display("[TB] basic block of 1.0");
        fillBlock(16'h3F80);
        applyStimulus(0, 0);

        $display("[TB] mixed magnitudes");
        fillBlock(16'h0000);
        blkData[0] = 16'h4380;
        blkData[1] = 16'hBF80;
        blkData[2] = 16'h3B80;
        blkData[3] = 16'h3A00;
        applyStimulus(0, 0);

        $display("[TB] saturation");
        fillBlock(16'h3FFF);
        applyStimulus(0, 0);

        $display("[TB] NaN block then clean block");
        fillBlock(16'h3F80);
        blkData[5] = 16'h7FC0;
        applyStimulus(0, 0);
        fillBlock(16'h3F80);
        applyStimulus(0, 0);

        $display("[TB] random gaps on 1.0 block");
        fillBlock(16'h3F80);
        applyStimulus(40, 0);

        $display("[TB] back-pressure then immediate next block");
        fillBlock(16'h4380);
        blkData[7] = 16'h8001;
        applyStimulus(0, 10);
        fillBlock(16'h0000);
        applyStimulus(0, 0);

        $display("[TB] reset mid-block");
        fillBlock(16'h4000);
        for (int i = 0; i < 17; i++) sendElement(blkData[i], 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("mid-reset in_ready", {263'd0, inReady}, 264'd1);
        checkOutput("mid-reset out_valid", {263'd0, outValid}, 264'd0);
        checkOutput("mid-reset out_vector", outVector, 264'd0);
        fillBlock(16'h3F80);
        applyStimulus(0, 0);

        $display("[TB] random blocks");
        for (int b = 0; b < 8; b++) begin
            fillRandom(b == 5);
            applyStimulus(int'($urandom_range(50)), (b == 3) ? 4 : 0);
        end

        w = 0;
        while (expQ.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkOutput("scoreboard drained", 264'(expQ.size()), 264'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
